// File: rtl/pc_gen.sv
// -----------------------------------------------------------------------------
// pc_gen : program counter / fetch address sequencer for the mini RISC-V core.
//
// Produces fetch addresses for instruction memory under a valid/ready
// handshake. It supports stall, redirect by branch, JALR or trap. A redirect
// that arrives while stalled is held in a one-entry pending buffer. A redirect
// to a misaligned target is turned into a jump to TRAP_VECTOR.
//
// Handshake: a fetch is accepted on a rising CLK edge where FetchValid and
// FetchReady are both high. The PC advances only on an accepted fetch. An
// applied redirect replaces the PC whatever FetchReady is, and drops the fetch
// in flight. FetchValid is low for one bubble cycle after a redirect.
//
// Ports:
//   CLK            in   clock, rising edge
//   Reset          in   synchronous active-high reset
//   Stall          in   freeze PC; live redirects are buffered while high
//   PCSrc[1:0]     in   00 seq, 01 branch, 10 JALR, 11 trap
//   PCTarget       in   branch/JAL target
//   ALUResult      in   JALR target (bit 0 cleared here)
//   FetchReady     in   instruction memory accepts PC this cycle
//   FetchValid     out  PC is a valid fetch request
//   PC             out  current fetch address
//   PCPlus4        out  PC + IALIGN (combinational, wraps)
//   MisalignedErr  out  one-cycle pulse after a misaligned redirect
//   BadAddr        out  last misaligned target
//   FetchCount     out  accepted sequential fetches (PC_GEN_FETCH_COUNT_EN only)
//   StateDbg       out  FSM state (0 = BOOT, 1 = RUN)
//
// Optional feature macro: PC_GEN_FETCH_COUNT_EN adds the FetchCount counter.
// -----------------------------------------------------------------------------
module pc_gen #(
   parameter int unsigned     XLEN         = 32,
   parameter logic [XLEN-1:0] RESET_VECTOR = 32'h0000_0000,
   parameter logic [XLEN-1:0] TRAP_VECTOR  = 32'h0000_0100,
   parameter int unsigned     IALIGN       = 4
) (
   input  logic            CLK,
   input  logic            Reset,
   input  logic            Stall,
   input  logic [1:0]      PCSrc,
   input  logic [XLEN-1:0] PCTarget,
   input  logic [XLEN-1:0] ALUResult,
   input  logic            FetchReady,
   output logic            FetchValid,
   output logic [XLEN-1:0] PC,
   output logic [XLEN-1:0] PCPlus4,
   output logic            MisalignedErr,
   output logic [XLEN-1:0] BadAddr,
`ifdef PC_GEN_FETCH_COUNT_EN
   output logic [31:0]     FetchCount,
`endif
   output logic            StateDbg
);

   localparam logic [0:0] ST_BOOT = 1'b0;
   localparam logic [0:0] ST_RUN  = 1'b1;

   localparam logic [XLEN-1:0] INC = XLEN'(IALIGN);

   logic [0:0]      state_q, state_d;
   logic [XLEN-1:0] pc_q, pc_d;
   logic            bubble_q, bubble_d;
   logic            err_q, err_d;
   logic [XLEN-1:0] bad_q, bad_d;
   // The pending buffer keeps the target already resolved from its PCSrc.
   // The source code itself is therefore not needed once it is captured.
   logic            pend_vld_q, pend_vld_d;
   logic [XLEN-1:0] pend_tgt_q, pend_tgt_d;

   logic            live_redir;
   logic [XLEN-1:0] live_tgt;
   logic            eff_redir;
   logic [XLEN-1:0] eff_tgt;
   logic            eff_misaligned;
   logic            fetch_fire;
   logic            advance;

   // Resolve the live redirect target from PCSrc.
   always_comb begin
      live_tgt = '0;
      case (PCSrc)
         2'b01:   live_tgt = PCTarget;
         2'b10:   live_tgt = {ALUResult[XLEN-1:1], 1'b0};
         2'b11:   live_tgt = TRAP_VECTOR;
         default: live_tgt = '0;
      endcase
   end

   assign live_redir = (PCSrc != 2'b00);
   // A live redirect has priority over the buffered one.
   assign eff_redir  = live_redir || pend_vld_q;
   assign eff_tgt    = live_redir ? live_tgt : pend_tgt_q;

   // With IALIGN=2 only bit 0 matters, so a JALR target is always aligned.
   assign eff_misaligned = (IALIGN == 4) ? (eff_tgt[1:0] != 2'b00) : eff_tgt[0];

   assign FetchValid = (state_q == ST_RUN) && !bubble_q;
   assign fetch_fire = FetchValid && FetchReady;

   always_comb begin
      state_d    = state_q;
      pc_d       = pc_q;
      bubble_d   = 1'b0;
      err_d      = 1'b0;
      bad_d      = bad_q;
      pend_vld_d = pend_vld_q;
      pend_tgt_d = pend_tgt_q;
      advance    = 1'b0;

      if (state_q == ST_BOOT) begin
         // Redirects are ignored in BOOT and never reach the pending buffer.
         state_d = ST_RUN;
      end else begin
         if (Stall) begin
            if (live_redir) begin
               pend_vld_d = 1'b1;
               pend_tgt_d = live_tgt;
            end
         end else if (eff_redir) begin
            if (eff_misaligned) begin
               pc_d  = TRAP_VECTOR;
               bad_d = eff_tgt;
               err_d = 1'b1;
            end else begin
               pc_d = eff_tgt;
            end
            pend_vld_d = 1'b0;
            bubble_d   = 1'b1;
         end else if (fetch_fire) begin
            pc_d    = pc_q + INC;
            advance = 1'b1;
         end
      end
   end

   always_ff @(posedge CLK) begin
      if (Reset) begin
         state_q    <= ST_BOOT;
         pc_q       <= RESET_VECTOR;
         bubble_q   <= 1'b0;
         err_q      <= 1'b0;
         bad_q      <= '0;
         pend_vld_q <= 1'b0;
         pend_tgt_q <= '0;
      end else begin
         state_q    <= state_d;
         pc_q       <= pc_d;
         bubble_q   <= bubble_d;
         err_q      <= err_d;
         bad_q      <= bad_d;
         pend_vld_q <= pend_vld_d;
         pend_tgt_q <= pend_tgt_d;
      end
   end

`ifdef PC_GEN_FETCH_COUNT_EN
   logic [31:0] cnt_q, cnt_d;

   // Counts only fetches that actually advance the PC.
   assign cnt_d = advance ? cnt_q + 32'd1 : cnt_q;

   always_ff @(posedge CLK) begin
      if (Reset) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

   assign FetchCount = cnt_q;
`else
   logic unused_advance;
   assign unused_advance = advance;
`endif

   assign PC            = pc_q;
   assign PCPlus4       = pc_q + INC;
   assign MisalignedErr = err_q;
   assign BadAddr       = bad_q;
   assign StateDbg      = state_q;

endmodule
